// File: rtl/data_memory_pipe.sv
// Data memory with a valid/ready request port, a fixed-latency response pipeline,
// per-byte write strobes, alignment/range error reporting and a post-reset clear sweep.
module data_memory_pipe #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 16,
    parameter int DEPTH  = 256,
    parameter int RD_LAT = 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_we,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [DATA_W-1:0]   req_wdata,
    input  logic [DATA_W/8-1:0] req_be,
    output logic                rsp_valid,
    output logic [DATA_W-1:0]   rsp_rdata,
    output logic                rsp_err,
    output logic                busy
);

    localparam int BYTES = DATA_W / 8;
    localparam int LSB_W = $clog2(BYTES);
    localparam int IDX_W = $clog2(DEPTH);
    localparam int LAST  = RD_LAT - 1;
    localparam logic [ADDR_W-1:0] LSB_MASK = ADDR_W'(BYTES - 1);
    localparam logic [ADDR_W:0]   DEPTH_W  = (ADDR_W + 1)'(DEPTH);
    localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(DEPTH - 1);
    localparam logic [IDX_W-1:0]  IDX_ONE  = IDX_W'(1);

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } state_t;

    state_t             state_r;
    state_t             state_nxt_s;
    logic [IDX_W-1:0]   clr_idx_r;
    logic [IDX_W-1:0]   clr_idx_nxt_s;
    logic               ready_r;
    logic               busy_r;

    logic [DATA_W-1:0]  ram_r [DEPTH];

    logic [ADDR_W-1:0]  word_s;
    logic [IDX_W-1:0]   idx_s;
    logic               misalign_s;
    logic               range_err_s;
    logic               err_s;
    logic               accept_s;
    logic               wr_en_s;
    logic               rd_en_s;
    logic               clr_en_s;

    logic [RD_LAT-1:0]  vld_r;
    logic [RD_LAT-1:0]  rd_r;
    logic [RD_LAT-1:0]  err_r;
    logic [DATA_W-1:0]  data_r [RD_LAT];

    // Address decode and request qualification; reset overrides any handshake.
    always_comb begin
        word_s      = req_addr >> LSB_W;
        idx_s       = word_s[IDX_W-1:0];
        misalign_s  = |(req_addr & LSB_MASK);
        range_err_s = ({1'b0, word_s} >= DEPTH_W);
        err_s       = misalign_s | range_err_s;
        accept_s    = req_valid & ready_r & ~reset;
        wr_en_s     = accept_s & req_we & ~err_s;
        rd_en_s     = accept_s & ~req_we & ~err_s;
        clr_en_s    = (state_r == ST_CLEAR) & ~reset;
    end

    // Next-state logic for the clear sweep; READY is only left through reset.
    always_comb begin
        state_nxt_s   = state_r;
        clr_idx_nxt_s = clr_idx_r;
        case (state_r)
            ST_CLEAR: begin
                clr_idx_nxt_s = clr_idx_r + IDX_ONE;
                if (clr_idx_r == IDX_LAST) begin
                    state_nxt_s = ST_READY;
                end else begin
                    state_nxt_s = ST_CLEAR;
                end
            end
            ST_READY: begin
                state_nxt_s = ST_READY;
            end
            default: begin
                state_nxt_s   = ST_CLEAR;
                clr_idx_nxt_s = '0;
            end
        endcase
    end

    // State register; ready/busy are registered from the next state so they flip on the same edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r   <= ST_CLEAR;
            clr_idx_r <= '0;
            ready_r   <= 1'b0;
            busy_r    <= 1'b1;
        end else begin
            state_r   <= state_nxt_s;
            clr_idx_r <= clr_idx_nxt_s;
            ready_r   <= (state_nxt_s == ST_READY);
            busy_r    <= (state_nxt_s == ST_CLEAR);
        end
    end

    // Storage array: sweep writes during CLEAR, strobed lane writes once READY.
    always_ff @(posedge clk) begin
        if (clr_en_s) begin
            ram_r[clr_idx_r] <= '0;
        end else if (wr_en_s) begin
            for (int k = 0; k < BYTES; k++) begin
                if (req_be[k]) begin
                    ram_r[idx_s][8*k +: 8] <= req_wdata[8*k +: 8];
                end
            end
        end
    end

    // Response pipeline: stage 0 samples the array on the acceptance edge, later stages shift.
    always_ff @(posedge clk) begin
        if (reset) begin
            vld_r <= '0;
            rd_r  <= '0;
            err_r <= '0;
            for (int i = 0; i < RD_LAT; i++) begin
                data_r[i] <= '0;
            end
        end else begin
            vld_r[0]  <= accept_s;
            rd_r[0]   <= accept_s & ~req_we;
            err_r[0]  <= accept_s & err_s;
            data_r[0] <= rd_en_s ? ram_r[idx_s] : '0;
            for (int i = 1; i < RD_LAT; i++) begin
                vld_r[i]  <= vld_r[i-1];
                rd_r[i]   <= rd_r[i-1];
                err_r[i]  <= err_r[i-1];
                data_r[i] <= data_r[i-1];
            end
        end
    end

    assign req_ready = ready_r;
    assign busy      = busy_r;
    assign rsp_valid = vld_r[LAST];
    assign rsp_err   = err_r[LAST];
    assign rsp_rdata = (rd_r[LAST] & ~err_r[LAST]) ? data_r[LAST] : '0;

endmodule

// File: tb/tb_data_memory_pipe.sv
// Scoreboard bench for data_memory_pipe: expected responses are queued at issue time
// and checked (data, error flag and arrival cycle) by a response monitor.
module tb_data_memory_pipe;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 16;
    localparam int DEPTH  = 256;
    localparam int RD_LAT = 3;

    logic              clk = 1'b0;
    logic              reset;
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic [1:0]        req_be;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;
    logic              busy;

    typedef struct {
        logic [15:0] data;
        logic        err;
        int          due;
    } exp_t;

    exp_t        sb_q[$];
    logic [15:0] mdl [DEPTH];
    int          cyc = 0;
    int          tests = 0;
    int          fails = 0;
    bit          mon_en = 1'b0;

    data_memory_pipe #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .RD_LAT(RD_LAT)
    ) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .busy(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Response monitor: every valid response must match the head of the scoreboard.
    always @(negedge clk) begin
        exp_t e;
        if (mon_en) begin
            if (rsp_valid === 1'b1) begin
                tests++;
                if (sb_q.size() == 0) begin
                    fails++;
                    $display("FAIL rsp_unexpected: got valid rdata=%h err=%b at cycle %0d, required no response",
                             rsp_rdata, rsp_err, cyc);
                end else begin
                    e = sb_q.pop_front();
                    if (rsp_rdata !== e.data || rsp_err !== e.err || cyc != e.due) begin
                        fails++;
                        $display("FAIL rsp_check: got rdata=%h err=%b cycle=%0d, required rdata=%h err=%b cycle=%0d",
                                 rsp_rdata, rsp_err, cyc, e.data, e.err, e.due);
                    end
                end
            end else if (rsp_valid !== 1'b0 || rsp_rdata !== 16'h0000 || rsp_err !== 1'b0) begin
                fails++;
                $display("FAIL rsp_idle: got valid=%b rdata=%h err=%b, required 0/0000/0",
                         rsp_valid, rsp_rdata, rsp_err);
            end
        end
    end

    // Drives one request for one cycle (entered and left on a negedge) and queues its expected response.
    task automatic send(input logic we, input logic [15:0] addr, input logic [15:0] wdata,
                        input logic [1:0] be);
        exp_t e;
        int   w;
        logic bad;
        w     = int'(addr >> 1);
        bad   = addr[0] | (w >= DEPTH);
        e.err = bad;
        e.data = 16'h0000;
        e.due = cyc + RD_LAT;
        if (!bad) begin
            if (we) begin
                if (be[0]) mdl[w][7:0]  = wdata[7:0];
                if (be[1]) mdl[w][15:8] = wdata[15:8];
            end else begin
                e.data = mdl[w];
            end
        end
        sb_q.push_back(e);
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wdata;
        req_be    = be;
        @(negedge clk);
        req_valid = 1'b0;
        req_addr  = 16'($urandom);
        req_wdata = 16'($urandom);
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while (sb_q.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        tests++;
        if (sb_q.size() != 0) begin
            fails++;
            $display("FAIL %s_drain: %0d responses outstanding, required 0", name, sb_q.size());
            sb_q.delete();
        end
    endtask

    task automatic wait_sweep(input string name);
        int k = 0;
        int busy_bad = 0;
        while (req_ready !== 1'b1 && k < 400) begin
            if (busy !== 1'b1) busy_bad++;
            @(negedge clk);
            k++;
        end
        tests++;
        if (k != DEPTH || busy !== 1'b0 || busy_bad != 0) begin
            fails++;
            $display("FAIL %s_sweep: ready after %0d cycles busy=%b busy_low_during_sweep=%0d, required %0d/0/0",
                     name, k, busy, busy_bad, DEPTH);
        end
    endtask

    task automatic read_all;
        for (int w = 0; w < DEPTH; w++) send(1'b0, 16'(w * 2), 16'h0000, 2'b00);
    endtask

    task automatic test_reset;
        reset = 1'b1;
        @(negedge clk);
        tests++;
        if (rsp_valid !== 1'b0 || rsp_rdata !== 16'h0000 || rsp_err !== 1'b0 ||
            req_ready !== 1'b0 || busy !== 1'b1) begin
            fails++;
            $display("FAIL reset_state: got valid=%b rdata=%h err=%b ready=%b busy=%b, required 0/0000/0/0/1",
                     rsp_valid, rsp_rdata, rsp_err, req_ready, busy);
        end
        reset  = 1'b0;
        mon_en = 1'b1;
        for (int i = 0; i < DEPTH; i++) mdl[i] = 16'h0000;
        wait_sweep("reset");
        read_all();
        wait_drain("reset");
    endtask

    task automatic test_write_read;
        send(1'b1, 16'h0010, 16'hBEEF, 2'b11);
        send(1'b0, 16'h0010, 16'h0000, 2'b00);
        wait_drain("write_read");
    endtask

    task automatic test_byte_enable;
        send(1'b1, 16'h0010, 16'h1234, 2'b01);
        send(1'b0, 16'h0010, 16'h0000, 2'b00);
        send(1'b1, 16'h0010, 16'h5678, 2'b10);
        send(1'b0, 16'h0010, 16'h0000, 2'b00);
        send(1'b1, 16'h0010, 16'hBEEF, 2'b10);
        send(1'b1, 16'h0010, 16'hFFFF, 2'b00);
        send(1'b0, 16'h0010, 16'h0000, 2'b00);
        wait_drain("byte_enable");
        tests++;
        if (mdl[8] !== 16'hBE34) begin
            fails++;
            $display("FAIL byte_enable_model: got %h, required BE34", mdl[8]);
        end
    endtask

    task automatic test_errors;
        send(1'b0, 16'h0011, 16'h0000, 2'b00);
        send(1'b0, 16'h0200, 16'h0000, 2'b00);
        send(1'b0, 16'hFFFE, 16'h0000, 2'b00);
        send(1'b1, 16'h0200, 16'hAAAA, 2'b11);
        send(1'b1, 16'h0011, 16'h5555, 2'b11);
        send(1'b0, 16'h0000, 16'h0000, 2'b00);
        send(1'b0, 16'h0010, 16'h0000, 2'b00);
        // Write-looking inputs without req_valid must not touch the array.
        req_we = 1'b1; req_addr = 16'h0010; req_wdata = 16'hDEAD; req_be = 2'b11;
        @(negedge clk);
        @(negedge clk);
        send(1'b0, 16'h0010, 16'h0000, 2'b00);
        wait_drain("errors");
    endtask

    task automatic test_back_to_back;
        for (int i = 0; i < 8; i++) send(1'b1, 16'(i * 2), 16'(16'h1100 + i * 16'h0111), 2'b11);
        for (int i = 0; i < 8; i++) send(1'b0, 16'(i * 2), 16'h0000, 2'b00);
        wait_drain("back_to_back");
    endtask

    task automatic test_reset_inflight;
        send(1'b0, 16'h0010, 16'h0000, 2'b00);
        send(1'b0, 16'h0002, 16'h0000, 2'b00);
        reset = 1'b1;
        sb_q.delete();
        @(negedge clk);
        tests++;
        if (rsp_valid !== 1'b0 || busy !== 1'b1 || req_ready !== 1'b0) begin
            fails++;
            $display("FAIL inflight_reset: got valid=%b busy=%b ready=%b, required 0/1/0",
                     rsp_valid, busy, req_ready);
        end
        reset = 1'b0;
        for (int i = 0; i < DEPTH; i++) mdl[i] = 16'h0000;
        wait_sweep("inflight");
        read_all();
        wait_drain("inflight");
    endtask

    initial begin
        #1000000;
        $display("FAIL timeout: simulation did not finish, required completion");
        $fatal(1, "timeout");
    end

    initial begin
        reset     = 1'b1;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_addr  = 16'h0000;
        req_wdata = 16'h0000;
        req_be    = 2'b00;
        test_reset();
        test_write_read();
        test_byte_enable();
        test_errors();
        test_back_to_back();
        test_reset_inflight();
        repeat (5) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
